// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   IF stage plus IF/ID pipeline register.
//   - Owns the PC and presents it to the memory controller's instruction port.
//   - Captures the combinationally returned instruction into the D stage.
//   - A start/halt FSM, driven by the synchronized switchStart level, gates
//     fetching.
//   - Applies hazard-unit stall/flush controls and EX-stage branch redirects.
//
// Optional feature macro: IFETCH_PERF_EN
//   When defined, the fetchCount and stallCount performance counter outputs
//   are added.
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-high
//   switchStart    in   1   board start switch (asynchronous level)
//   stallF         in   1   hold PC
//   stallD         in   1   hold IF/ID register
//   flushD         in   1   bubble IF/ID register
//   pcSrcE         in   1   taken branch/jump resolved in EX
//   branchTargetE  in   32  redirect address from EX
//   instruction    in   32  instruction word for pc (same-cycle read)
//   pc             out  32  fetch address
//   instrD         out  32  D-stage instruction
//   pcD            out  32  D-stage PC
//   pcPlus4D       out  32  pcD + 4
//   validD         out  1   D stage holds a real instruction
//   running        out  1   FSM in RUN
//   fetchCount     out  32  (IFETCH_PERF_EN) valid D loads since start
//   stallCount     out  32  (IFETCH_PERF_EN) RUN cycles stalled by stallF
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        switchStart,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcE,
  input  logic [31:0] branchTargetE,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        running
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // First address past the end of instruction memory; sequential fetch wraps here.
  localparam logic [31:0] PC_LIMIT = RESET_PC + (32'(IMEM_WORDS) << 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sw_meta;
  logic        r_sw_q;
  logic        r_sw_q_d;
  logic [31:0] r_pc;
  logic [31:0] r_instrD;
  logic [31:0] r_pcD;
  logic [31:0] r_pcPlus4D;
  logic        r_validD;
  logic        r_running;

  logic        w_rise;
  logic        w_run;
  logic        w_start;
  logic        w_halt_hit;
  logic        w_bubble;
  logic        w_load;
  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_nxt;
  logic        w_unused;

  // Redirect targets are word-aligned by dropping the low bits.
  assign w_unused = ^branchTargetE[1:0];

  assign w_rise     = r_sw_q & ~r_sw_q_d;
  assign w_run      = (r_state == ST_RUN);
  assign w_start    = (r_state == ST_IDLE) & w_rise;
  // The halt word only counts once it is actually leaving D.
  assign w_halt_hit = w_run & r_validD & (r_instrD == HALT_INSTR) & ~stallD & ~flushD;
  assign w_bubble   = flushD | pcSrcE | ~w_run;
  assign w_load     = ~w_bubble & ~stallD;

  assign w_pc_inc   = r_pc + 32'd4;
  assign w_pc_seq   = (w_pc_inc == PC_LIMIT) ? RESET_PC : w_pc_inc;

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_start) begin
      w_pc_nxt = RESET_PC;
    end else if (w_run) begin
      if (pcSrcE) begin
        w_pc_nxt = {branchTargetE[31:2], 2'b00};
      end else if (!stallF) begin
        w_pc_nxt = w_pc_seq;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_rise)     w_state_nxt = ST_RUN;
      ST_RUN:  if (w_halt_hit) w_state_nxt = ST_HALT;
      ST_HALT: if (!r_sw_q)    w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta  <= 1'b0;
      r_sw_q     <= 1'b0;
      r_sw_q_d   <= 1'b0;
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_pc       <= RESET_PC;
      r_instrD   <= NOP_INSTR;
      r_pcD      <= '0;
      r_pcPlus4D <= 32'd4;
      r_validD   <= 1'b0;
    end else begin
      r_sw_meta <= switchStart;
      r_sw_q    <= r_sw_meta;
      r_sw_q_d  <= r_sw_q;
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_pc      <= w_pc_nxt;
      if (w_bubble) begin
        // pcD/pcPlus4D deliberately keep their last values on a bubble.
        r_instrD <= NOP_INSTR;
        r_validD <= 1'b0;
      end else if (w_load) begin
        r_instrD   <= instruction;
        r_pcD      <= r_pc;
        r_pcPlus4D <= w_pc_inc;
        r_validD   <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Counting only happens in RUN, so both values freeze in HALT.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load)                     r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_run && stallF && !pcSrcE) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetchCount = r_fetch_cnt;
  assign stallCount = r_stall_cnt;
`endif

  assign pc       = r_pc;
  assign instrD   = r_instrD;
  assign pcD      = r_pcD;
  assign pcPlus4D = r_pcPlus4D;
  assign validD   = r_validD;
  assign running  = r_running;

endmodule
